// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, binary32 field layout and fpu_sqrt_ctrl state encoding
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SPECIAL,
    S_NORM,
    S_ITER,
    S_ROUND,
    S_DONE
  } sqrt_state_e;
endpackage

// File: rtl/sqrt_radix2_step.sv
// sqrt_radix2_step: one restoring radix-2 square-root step, consumes two radicand bits
module sqrt_radix2_step #(
  parameter int W = 26
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   pair,
  output logic [W+1:0] rem_nxt,
  output logic         q_bit
);
  logic [W+1:0] sh, trial;
  always_comb begin
    sh = (rem << 2) | (W+2)'(pair);
    trial = {root, 2'b01};
    q_bit = sh >= trial;
    rem_nxt = q_bit ? sh - trial : sh;
  end
endmodule

// File: rtl/fpu_sqrt_ctrl.sv
// fpu_sqrt_ctrl: FSQRT.S sequencer; define FPU_SQRT_EARLY_OUT_EN to finish perfect squares early
module fpu_sqrt_ctrl #(
  parameter int          ITERS     = 26,
  parameter logic [31:0] CANON_NAN = fpu_pkg::CANON_NAN
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rm_i,
  input  logic [2:0]  frm_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o,
  output logic        rm_err_o
);
  import fpu_pkg::*;
  localparam int RW = ITERS + 2;
  localparam int DW = 2 * ITERS;
  sqrt_state_e state, state_nxt;
  logic [31:0] op_q, res_q, spec_res, rnd_res;
  logic [2:0] rm_q;
  logic [4:0] cnt, flg_q, lz;
  logic [DW-1:0] rad, rad_init;
  logic [RW-1:0] rem, rem_nxt;
  logic [ITERS-1:0] root, root_nxt;
  logic [7:0] exp_r, exp_res;
  logic [23:0] m24, m_n;
  logic signed [9:0] e_raw, e_adj;
  logic sgn, is_nan, is_snan, is_inf, is_zero, special, spec_nv;
  logic qb, eo, last, accept, g, r, s, inc;

  sqrt_radix2_step #(.W(ITERS)) u_step (
    .rem     (rem),
    .root    (root),
    .pair    (rad[DW-1 -: 2]),
    .rem_nxt (rem_nxt),
    .q_bit   (qb)
  );

  always_comb begin
    sgn = op_q[31];
    is_nan = (&op_q[30:23]) && (|op_q[22:0]);
    is_snan = is_nan && !op_q[22];
    is_inf = (&op_q[30:23]) && !(|op_q[22:0]);
    is_zero = !(|op_q[30:0]);
    special = is_nan || is_zero || is_inf || sgn;
    spec_nv = is_snan || (sgn && !is_zero && !is_nan);
    spec_res = (is_nan || (sgn && !is_zero)) ? CANON_NAN : op_q;
  end

  // Subnormals get the implicit bit from a left shift; exponent is -126 - lz.
  always_comb begin
    m24 = {|op_q[30:23], op_q[22:0]};
    lz = '0;
    for (int i = 0; i < 24; i++)
      if (m24[i]) lz = 5'(23 - i);
    m_n = m24 << lz;
    e_raw = 10'({2'b0, (|op_q[30:23]) ? op_q[30:23] : 8'd1}) - 10'd127 - 10'(lz);
    e_adj = e_raw - 10'(e_raw[0]);
    exp_res = 8'(e_adj >>> 1) + 8'd127;
    rad_init = e_raw[0] ? {m_n, 1'b0, {(DW-25){1'b0}}} : {1'b0, m_n, {(DW-25){1'b0}}};
  end

  always_comb begin
    root_nxt = {root[ITERS-2:0], qb};
`ifdef FPU_SQRT_EARLY_OUT_EN
    eo = (rem_nxt == '0) && (rad[DW-3:0] == '0);
`else
    eo = 1'b0;
`endif
    last = (cnt == 5'(ITERS-1)) || eo;
  end

  // A tie is impossible for sqrt, so RNE and RMM both reduce to rounding on G.
  always_comb begin
    g = root[ITERS-25];
    r = root[ITERS-26];
    s = |rem;
    inc = (rm_q == RM_RUP) ? (g | r | s) : (rm_q == RM_RTZ || rm_q == RM_RDN) ? 1'b0 : g;
    rnd_res = {1'b0, exp_r, root[ITERS-2 -: 23]} + 32'(inc);
  end

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) state <= S_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = start_i ? S_UNPACK : S_IDLE;
      S_UNPACK:  state_nxt = special ? S_SPECIAL : S_NORM;
      S_SPECIAL: state_nxt = S_DONE;
      S_NORM:    state_nxt = S_ITER;
      S_ITER:    state_nxt = last ? S_ROUND : S_ITER;
      S_ROUND:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (kill_i) state_nxt = S_IDLE;
  end

  always_comb begin
    accept = (state == S_IDLE) && start_i && !kill_i;
    busy_o = state != S_IDLE;
    done_o = (state == S_DONE) && !kill_i;
    rm_err_o = done_o && (rm_q >= 3'd5);
    result_o = res_q;
    flags_o = flg_q;
  end

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      op_q <= '0;
      rm_q <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      exp_r <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (accept) begin
        op_q <= operand_i;
        rm_q <= (rm_i == RM_DYN) ? frm_i : rm_i;
      end
      if (state == S_NORM) begin
        rad <= rad_init;
        rem <= '0;
        root <= '0;
        cnt <= '0;
        exp_r <= exp_res;
      end
      if (state == S_ITER) begin
        rem <= rem_nxt;
        root <= eo ? root_nxt << (5'(ITERS-1) - cnt) : root_nxt;
        rad <= rad << 2;
        cnt <= cnt + 5'd1;
      end
      if (state_nxt == S_DONE) begin
        res_q <= (state == S_SPECIAL) ? spec_res : rnd_res;
        flg_q <= (state == S_SPECIAL) ? {spec_nv, 4'b0} : {4'b0, g | r | s};
      end
    end
endmodule

// File: tb/tb_fpu_sqrt_ctrl.sv
// tb_fpu_sqrt_ctrl: directed-vector check of fpu_sqrt_ctrl results, flags and latency
module tb_fpu_sqrt_ctrl;
  import fpu_pkg::*;
`ifdef FPU_SQRT_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  localparam int L_FULL = 29;
  localparam int L_SPEC = 2;
  localparam int L_PERF1 = EO ? 4 : 29;
  localparam int L_PERF2 = EO ? 5 : 29;
  logic clk = 0, reset_i = 0, start_i = 0, kill_i = 0;
  logic [31:0] operand_i = '0;
  logic [2:0] rm_i = '0, frm_i = '0;
  logic busy_o, done_o, rm_err_o;
  logic [31:0] result_o;
  logic [4:0] flags_o;
  int vectors = 0, errs = 0, lat = 0, dn = 0;
  logic [31:0] res;
  logic [4:0] flg;
  logic rerr;

  fpu_sqrt_ctrl dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .operand_i (operand_i),
    .rm_i      (rm_i),
    .frm_i     (frm_i),
    .kill_i    (kill_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .flags_o   (flags_o),
    .rm_err_o  (rm_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] op, input logic [2:0] rm, input logic [2:0] frm);
    @(negedge clk);
    operand_i = op;
    rm_i = rm;
    frm_i = frm;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    lat = 0;
  endtask

  task automatic wait_done(input string tag);
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done_o) check({tag, ".done_seen"}, 32'(done_o), 32'd1);
    res = result_o;
    flg = flags_o;
    rerr = rm_err_o;
  endtask

  task automatic do_vec(input string tag, input logic [31:0] op, input logic [2:0] rm,
                        input logic [2:0] frm, input logic [31:0] exp_res, input logic [4:0] exp_flg,
                        input logic exp_rerr, input int exp_lat);
    launch(op, rm, frm);
    wait_done(tag);
    check({tag, ".res"}, res, exp_res);
    check({tag, ".flags"}, 32'(flg), 32'(exp_flg));
    check({tag, ".rm_err"}, 32'(rerr), 32'(exp_rerr));
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy_o), 0);
    check("rst.done", 32'(done_o), 0);
    check("rst.res", result_o, 0);
    check("rst.flags", 32'(flags_o), 0);
    check("rst.rm_err", 32'(rm_err_o), 0);
    reset_i = 1;

    do_vec("sqrt4", 32'h40800000, RM_RNE, 3'd0, 32'h40000000, 5'h00, 0, L_PERF1);
    @(negedge clk);
    check("sqrt4.pulse", 32'(done_o), 0);
    do_vec("sqrt2.rne", 32'h40000000, RM_RNE, 3'd0, 32'h3FB504F3, 5'h01, 0, L_FULL);
    do_vec("sqrt2.rup", 32'h40000000, RM_RUP, 3'd0, 32'h3FB504F4, 5'h01, 0, L_FULL);
    do_vec("sqrt2.rtz", 32'h40000000, RM_RTZ, 3'd0, 32'h3FB504F3, 5'h01, 0, L_FULL);
    do_vec("sqrt2.rdn", 32'h40000000, RM_RDN, 3'd0, 32'h3FB504F3, 5'h01, 0, L_FULL);
    do_vec("sqrt2.rmm", 32'h40000000, RM_RMM, 3'd0, 32'h3FB504F3, 5'h01, 0, L_FULL);
    do_vec("neg1", 32'hBF800000, RM_RNE, 3'd0, 32'h7FC00000, 5'h10, 0, L_SPEC);
    do_vec("negzero", 32'h80000000, RM_RNE, 3'd0, 32'h80000000, 5'h00, 0, L_SPEC);
    do_vec("snan", 32'h7F800001, RM_RNE, 3'd0, 32'h7FC00000, 5'h10, 0, L_SPEC);
    do_vec("qnan", 32'h7FC00000, RM_RNE, 3'd0, 32'h7FC00000, 5'h00, 0, L_SPEC);
    do_vec("pinf", 32'h7F800000, RM_RNE, 3'd0, 32'h7F800000, 5'h00, 0, L_SPEC);
    do_vec("ninf", 32'hFF800000, RM_RNE, 3'd0, 32'h7FC00000, 5'h10, 0, L_SPEC);
    do_vec("sub.rne", 32'h00000001, RM_RNE, 3'd0, 32'h1A3504F3, 5'h01, 0, L_FULL);
    do_vec("sub.dyn_rdn", 32'h00000001, RM_DYN, RM_RDN, 32'h1A3504F3, 5'h01, 0, L_FULL);
    do_vec("sub.dyn_rup", 32'h00000001, RM_DYN, RM_RUP, 32'h1A3504F4, 5'h01, 0, L_FULL);
    do_vec("sub.rm101", 32'h00000001, 3'b101, 3'd0, 32'h1A3504F3, 5'h01, 1, L_FULL);
    do_vec("sqrt9", 32'h41100000, RM_RNE, 3'd0, 32'h40400000, 5'h00, 0, L_PERF2);
    do_vec("quarter", 32'h3E800000, RM_RNE, 3'd0, 32'h3F000000, 5'h00, 0, L_PERF1);
    do_vec("half", 32'h3F000000, RM_RNE, 3'd0, 32'h3F3504F3, 5'h01, 0, L_FULL);
    do_vec("sqrt16", 32'h41800000, RM_RNE, 3'd0, 32'h40800000, 5'h00, 0, L_PERF1);

    // kill during the recurrence
    launch(32'h40000000, RM_RNE, 3'd0);
    repeat (12) @(negedge clk);
    kill_i = 1;
    @(negedge clk);
    kill_i = 0;
    check("kill.busy", 32'(busy_o), 0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done_o);
    end
    check("kill.no_done", 32'(dn), 0);
    check("kill.res_hold", result_o, 32'h40800000);
    @(negedge clk);
    operand_i = 32'h40800000;
    start_i = 1;
    kill_i = 1;
    @(negedge clk);
    start_i = 0;
    kill_i = 0;
    check("kill_accept.busy", 32'(busy_o), 0);
    do_vec("after_kill", 32'h41100000, RM_RNE, 3'd0, 32'h40400000, 5'h00, 0, L_PERF2);

    // start while busy is ignored
    launch(32'h40000000, RM_RNE, 3'd0);
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    operand_i = 32'h40800000;
    start_i = 1;
    @(negedge clk);
    lat++;
    start_i = 0;
    check("busy_start.busy", 32'(busy_o), 1);
    check("busy_start.res_hold", result_o, 32'h40400000);
    wait_done("busy_start");
    check("busy_start.res", res, 32'h3FB504F3);
    check("busy_start.lat", 32'(lat), 32'(L_FULL));
    @(negedge clk);
    check("busy_start.no_queue", 32'(busy_o), 0);

    // async reset mid-recurrence
    launch(32'h40000000, RM_RNE, 3'd0);
    repeat (10) @(negedge clk);
    reset_i = 0;
    #1;
    check("rst_mid.res", result_o, 0);
    check("rst_mid.flags", 32'(flags_o), 0);
    check("rst_mid.busy", 32'(busy_o), 0);
    check("rst_mid.done", 32'(done_o), 0);
    @(negedge clk);
    reset_i = 1;
    do_vec("after_rst", 32'h40800000, RM_RNE, 3'd0, 32'h40000000, 5'h00, 0, L_PERF1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
